// File: rtl/road_sign_seq.sv
// road_sign_seq: road-sign controller driving an N-LED arrow bar and an RGB
// status LED from four one-hot buttons. Supports accumulating LEFT/RIGHT chase
// patterns, a WARNING blink, rising-edge press detection with priority
// arbitration, and SAFE-centred legal transitions.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   btn      in   [0]=LEFT [1]=RIGHT [2]=WARNING [3]=SAFE, synchronous to clk
//   led      out  arrow LED bar (decoded from registered state)
//   rgb_led  out  status LED {R,G,B} (decoded from registered state)
//   mode     out  0=SAFE 1=LEFT 2=RIGHT 3=WARNING
//
// Optional feature: define ROAD_SIGN_BTN_SYNC_EN to pass btn through a
// 2-flop synchroniser (reset to all-ones) ahead of edge detection.
module road_sign_seq #(
    parameter int unsigned N_LEDS      = 4,
    parameter int unsigned STEP_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        btn,
    output logic [N_LEDS-1:0] led,
    output logic [2:0]        rgb_led,
    output logic [1:0]        mode
);

    localparam int unsigned CW    = $clog2(STEP_CYCLES);
    // STEP_CYCLES=1 gives CW=0; keep at least one counter bit.
    localparam int unsigned CNT_W = (CW > 0) ? CW : 1;
    localparam int unsigned IDX_W = $clog2(N_LEDS + 1);

    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_LEDS);
    localparam logic [N_LEDS-1:0] ONES      = '1;

    typedef enum logic [1:0] {
        MODE_SAFE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_WARN  = 2'd3
    } mode_e;

    logic [3:0] btn_s;

`ifdef ROAD_SIGN_BTN_SYNC_EN
    // Two-flop synchroniser; all-ones reset so held buttons are not pressed.
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;
`else
    assign btn_s = btn;
`endif

    mode_e            mode_q,     mode_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             phase_q,    phase_d;
    logic [3:0]       btn_prev_q, btn_prev_d;

    logic [3:0] press;
    logic       req_valid;
    mode_e      req_mode;
    logic       accept;
    logic       step;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_SAFE;
            cnt_q      <= '0;
            idx_q      <= '0;
            phase_q    <= 1'b0;
            btn_prev_q <= 4'b1111;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    // Press arbitration, transition rules and pattern stepping.
    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        btn_prev_d = btn_s;
        req_valid  = 1'b1;
        req_mode   = MODE_SAFE;

        press = btn_s & ~btn_prev_q;

        if (press[3]) begin
            req_mode = MODE_SAFE;
        end else if (press[2]) begin
            req_mode = MODE_WARN;
        end else if (press[1]) begin
            req_mode = MODE_RIGHT;
        end else if (press[0]) begin
            req_mode = MODE_LEFT;
        end else begin
            req_valid = 1'b0;
        end

        // Only SAFE may leave to another mode; everything else may only return to SAFE.
        accept = req_valid && (req_mode != mode_q)
                 && ((mode_q == MODE_SAFE) || (req_mode == MODE_SAFE));
        step   = (mode_q != MODE_SAFE) && (cnt_q == STEP_LAST);

        if (accept) begin
            // First pattern of the new mode is shown from this edge.
            mode_d  = req_mode;
            cnt_d   = '0;
            idx_d   = ((req_mode == MODE_LEFT) || (req_mode == MODE_RIGHT))
                      ? IDX_W'(1) : '0;
            phase_d = (req_mode == MODE_WARN);
        end else if (mode_q == MODE_SAFE) begin
            cnt_d   = '0;
            idx_d   = '0;
            phase_d = 1'b0;
        end else begin
            cnt_d = step ? '0 : cnt_q + CNT_W'(1);
            if (step) begin
                case (mode_q)
                    MODE_LEFT, MODE_RIGHT: idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    MODE_WARN:             phase_d = ~phase_q;
                    default:               ;
                endcase
            end
        end
    end

    // Output decode of registered state.
    always_comb begin
        led     = '0;
        rgb_led = 3'b010;
        mode    = mode_q;
        case (mode_q)
            MODE_LEFT: begin
                led     = ~(ONES >> idx_q);
                rgb_led = 3'b110;
            end
            MODE_RIGHT: begin
                led     = ~(ONES << idx_q);
                rgb_led = 3'b110;
            end
            MODE_WARN: begin
                led     = phase_q ? ONES : '0;
                rgb_led = phase_q ? 3'b100 : 3'b000;
            end
            default: begin
                led     = '0;
                rgb_led = 3'b010;
            end
        endcase
    end

endmodule

// File: tb/tb_road_sign_seq.sv
// Testbench for road_sign_seq (N_LEDS=4, STEP_CYCLES=4, 10 ns clock).
// Reference model tracks mode and cycles-since-entry; patterns are derived
// arithmetically from that elapsed time.
module tb_road_sign_seq;

    localparam int N    = 4;
    localparam int STEP = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   btn;
    logic [N-1:0] led;
    logic [2:0]   rgb_led;
    logic [1:0]   mode;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int         m_mode = 0;
    int         m_t    = 0;
    logic [3:0] m_prev = 4'b1111;

    always #5 clk = ~clk;

    road_sign_seq #(.N_LEDS(N), .STEP_CYCLES(STEP)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .led     (led),
        .rgb_led (rgb_led),
        .mode    (mode)
    );

    task automatic model_step(input logic r, input logic [3:0] b);
        logic [3:0] p;
        int req;
        if (r) begin
            m_mode = 0;
            m_t    = 0;
            m_prev = 4'b1111;
            return;
        end
        p      = b & ~m_prev;
        m_prev = b;
        if (p[3])      req = 0;
        else if (p[2]) req = 3;
        else if (p[1]) req = 2;
        else if (p[0]) req = 1;
        else           req = -1;
        if (req >= 0 && req != m_mode && (m_mode == 0 || req == 0)) begin
            m_mode = req;
            m_t    = 0;
        end else if (m_mode != 0) begin
            m_t++;
        end
    endtask

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] v;
        int lit;
        v   = '0;
        lit = (1 + m_t / STEP) % (N + 1);
        case (m_mode)
            1: for (int k = 0; k < N; k++) if (k >= N - lit) v[k] = 1'b1;
            2: for (int k = 0; k < N; k++) if (k < lit) v[k] = 1'b1;
            3: if ((m_t / STEP) % 2 == 0) v = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] exp_rgb();
        case (m_mode)
            1, 2:    return 3'b110;
            3:       return ((m_t / STEP) % 2 == 0) ? 3'b100 : 3'b000;
            default: return 3'b010;
        endcase
    endfunction

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic tick(input logic r, input logic [3:0] b);
        reset = r;
        btn   = b;
        @(posedge clk);
        model_step(r, b);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 7; c++) begin
            tick(c < 2, 4'b0000);
            n_total++;
            if ({mode, rgb_led, led} !== {2'd0, 3'b010, 4'b0000}) begin
                $display("FAIL reset/idle cyc %0d: got mode=%0d rgb=%b led=%b, want mode=0 rgb=010 led=0000",
                         c, mode, rgb_led, led);
            end else n_pass++;
        end
    endtask

    task automatic test_left();
        logic [3:0] tbl [6];
        tbl = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b1000};
        for (int j = 0; j <= 20; j++) begin
            tick(1'b0, (j == 0) ? 4'b0001 : 4'b0000);
            n_total++;
            if ({mode, rgb_led, led} !== {2'd1, 3'b110, tbl[j / 4]}) begin
                $display("FAIL left_chase j=%0d: got mode=%0d rgb=%b led=%b, want mode=1 rgb=110 led=%b",
                         j, mode, rgb_led, led, tbl[j / 4]);
            end else n_pass++;
        end
    endtask

    task automatic test_illegal();
        logic [3:0] seq [5];
        seq = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, seq[j]);
            n_total++;
            if (mode !== 2'd1 || {rgb_led, led} !== {exp_rgb(), exp_led()}) begin
                $display("FAIL illegal_drop j=%0d: got mode=%0d rgb=%b led=%b, want mode=1 rgb=%b led=%b",
                         j, mode, rgb_led, led, exp_rgb(), exp_led());
            end else n_pass++;
        end
        tick(1'b0, 4'b1000);
        n_total++;
        if ({mode, rgb_led, led} !== {2'd0, 3'b010, 4'b0000}) begin
            $display("FAIL left_to_safe: got mode=%0d rgb=%b led=%b, want mode=0 rgb=010 led=0000",
                     mode, rgb_led, led);
        end else n_pass++;
    endtask

    task automatic test_warning();
        logic [6:0] want;
        for (int j = 0; j < 17; j++) begin
            tick(1'b0, (j == 0) ? 4'b0100 : 4'b0000);
            want = ((j / 4) % 2 == 0) ? {3'b100, 4'b1111} : {3'b000, 4'b0000};
            n_total++;
            if (mode !== 2'd3 || {rgb_led, led} !== want) begin
                $display("FAIL warning_blink j=%0d: got mode=%0d rgb=%b led=%b, want mode=3 rgb/led=%b",
                         j, mode, rgb_led, led, want);
            end else n_pass++;
        end
        tick(1'b0, 4'b1000);
        n_total++;
        if (mode !== 2'd0) begin
            $display("FAIL warning_to_safe: got mode=%0d, want 0", mode);
        end else n_pass++;
    endtask

    task automatic test_priority();
        tick(1'b0, 4'b0110);
        n_total++;
        if ({mode, rgb_led, led} !== {2'd3, 3'b100, 4'b1111}) begin
            $display("FAIL priority_warn_over_right: got mode=%0d rgb=%b led=%b, want mode=3 rgb=100 led=1111",
                     mode, rgb_led, led);
        end else n_pass++;
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b1001);
        n_total++;
        if (mode !== 2'd0) begin
            $display("FAIL priority_safe_over_left: got mode=%0d, want 0", mode);
        end else n_pass++;
    endtask

    task automatic test_reset_held();
        tick(1'b1, 4'b0001);
        for (int j = 0; j < 3; j++) begin
            tick(1'b0, 4'b0001);
            n_total++;
            if (mode !== 2'd0 || led !== 4'b0000) begin
                $display("FAIL held_through_reset j=%0d: got mode=%0d led=%b, want mode=0 led=0000",
                         j, mode, led);
            end else n_pass++;
        end
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0001);
        n_total++;
        if (mode !== 2'd1 || led !== 4'b1000) begin
            $display("FAIL repress_after_reset: got mode=%0d led=%b, want mode=1 led=1000", mode, led);
        end else n_pass++;
        tick(1'b0, 4'b1000);
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 4'b0010);
        for (int j = 0; j < 8; j++) tick(1'b0, 4'b0000);
        n_total++;
        if (mode !== 2'd2 || led !== 4'b0111) begin
            $display("FAIL right_before_reset: got mode=%0d led=%b, want mode=2 led=0111", mode, led);
        end else n_pass++;
        tick(1'b1, 4'b0100);
        n_total++;
        if ({mode, rgb_led, led} !== {2'd0, 3'b010, 4'b0000}) begin
            $display("FAIL reset_mid_pattern: got mode=%0d rgb=%b led=%b, want mode=0 rgb=010 led=0000",
                     mode, rgb_led, led);
        end else n_pass++;
        tick(1'b0, 4'b0000);
    endtask

    task automatic test_random();
        logic       r;
        logic [3:0] b;
        b = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) b = 4'b0000;
            tick(r, b);
            n_total++;
            if ({mode, rgb_led, led} !== {2'(m_mode), exp_rgb(), exp_led()}) begin
                $display("FAIL random cyc %0d: got mode=%0d rgb=%b led=%b, want mode=%0d rgb=%b led=%b",
                         c, mode, rgb_led, led, m_mode, exp_rgb(), exp_led());
            end else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = 4'b0000;
        test_reset();
        test_left();
        test_illegal();
        test_warning();
        test_priority();
        test_reset_held();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/road_sign_seq.md
Name: road_sign_seq

Overview:
- Parametrised next-generation road-sign controller. Drives an N-LED arrow bar and an RGB status LED from four one-hot buttons.
- Adds over the fixed 4-LED sign:
  - sequential (accumulating) chase patterns with a programmable step period;
  - rising-edge button detection;
  - legal-transition rules;
  - a registered mode status output.
- Sits between the board button inputs and the LED bank in the top level.

Parameters:
- N_LEDS, 4, number of arrow LEDs (≥2).
- STEP_CYCLES, 25_000_000, clock cycles per pattern step (≥1; benches use 4).
- CW, $clog2(STEP_CYCLES), width of the step counter (derived localparam, not user-set).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn  input  4  buttons, synchronous to clk: [0]=LEFT, [1]=RIGHT, [2]=WARNING, [3]=SAFE.
- led  output  N_LEDS  arrow LED bar.
- rgb_led  output  3  status LED, {R,G,B}.
- mode  output  2  current mode: 0=SAFE, 1=LEFT, 2=RIGHT, 3=WARNING.

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - Reset is synchronous and active-high.
  - While reset is high at a rising edge, the next state is: mode=SAFE, step counter=0, chase index=0, blink phase=0, btn_prev=4'b1111.
  - With btn_prev reset to all-ones, a button held through reset is ignored until released and re-pressed.
  - Reset values of outputs: led=0, rgb_led=3'b010, mode=2'd0.
- Press detection and arbitration:
  - press = btn & ~btn_prev; btn_prev <= btn every cycle.
  - Multiple presses in one cycle: priority SAFE > WARNING > RIGHT > LEFT; the lower ones are discarded.
- Legal transitions:
  - SAFE -> any mode.
  - LEFT, RIGHT, WARNING -> SAFE only.
  - A press of the current mode is ignored.
  - Illegal requests are dropped, with no side effect and no restart of the pattern.
- Latency:
  - An accepted press updates mode at the clock edge where btn is first sampled high.
  - led, rgb_led and mode are combinational decodes of registered state, so they reflect the new mode from that edge.
- On an accepted transition:
  - step counter <= 0;
  - chase index <= 1 (LEFT/RIGHT);
  - blink phase <= 1 (WARNING).
  - The first pattern is therefore visible immediately.
- Step timer:
  - Counts 0..STEP_CYCLES-1, then wraps to 0.
  - Free-runs only in LEFT, RIGHT and WARNING; held at 0 in SAFE.
  - A step fires on the cycle the counter equals STEP_CYCLES-1.
- LEFT:
  - Chase index i runs 0..N_LEDS, then wraps to 0, advancing once per step.
  - led = top i bits set (N=4: 0000, 1000, 1100, 1110, 1111, 0000, ...).
  - rgb_led = 3'b110.
- RIGHT:
  - Same chase index; led = bottom i bits set (0001, 0011, 0111, 1111, 0000, ...).
  - rgb_led = 3'b110.
- WARNING:
  - Blink phase toggles once per step.
  - led = all ones when phase=1, else all zeros.
  - rgb_led = 3'b100 when phase=1, else 3'b000.
- SAFE: led = 0; rgb_led = 3'b010.
- Reset mid-pattern overrides any same-cycle press.
- A press on the same edge as a step event: the transition wins and the counter restarts.

Optional Feature:
- Macro: ROAD_SIGN_BTN_SYNC_EN.
- Defined:
  - btn passes through a 2-flop synchroniser (reset value 4'b1111) before edge detection.
  - Press-to-output latency becomes 3 clock edges after btn is first high.
  - Use for asynchronous board buttons.
- Undefined: btn is used directly, with the 1-edge latency described above.

Test Plan (N_LEDS=4, STEP_CYCLES=4, 10 ns clock):
1. Reset 2 cycles, release, idle 5 cycles -> led=0000, rgb_led=010, mode=0 throughout.
2. From SAFE, pulse btn=0001 for 1 cycle:
   - mode=1 and led=1000 at the sampling edge;
   - then 1100, 1110, 1111, 0000, 1000 every 4 cycles;
   - rgb_led=110.
3. While in LEFT, pulse btn=0010, then btn=0100 -> mode stays 1 and the chase sequence continues unbroken. Then pulse btn=1000 -> mode=0, led=0000, rgb_led=010 at that edge.
4. From SAFE, pulse btn=0100:
   - led=1111 and rgb_led=100 for 4 cycles;
   - then led=0000 and rgb_led=000 for 4 cycles;
   - repeating.
5. From SAFE, pulse btn=0110 in one cycle -> WARNING is entered (priority over RIGHT).
6. Simultaneous events:
   - Hold btn=0001 across a reset pulse and keep it held -> mode stays SAFE; release and press again -> LEFT.
   - Assert reset during RIGHT with led=0111 -> next edge: SAFE, led=0000.
